// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB) with
//            memory-wait timeout and a retired-instruction counter.
//            Optional macro ILLEGAL_TRAP_EN: an illegal opcode traps to TRAP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int OP_W        = 11,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             branch,
    output logic [1:0]       aluop,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             mem_err,
    output logic             illegal
);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEM    = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_TRAP   = 3'd5;

    localparam logic [2:0] c_K_NOP   = 3'd0;
    localparam logic [2:0] c_K_LDUR  = 3'd1;
    localparam logic [2:0] c_K_STUR  = 3'd2;
    localparam logic [2:0] c_K_CBZ   = 3'd3;
    localparam logic [2:0] c_K_RTYPE = 3'd4;
    localparam logic [2:0] c_K_ILL   = 3'd5;

    localparam int                  c_WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX = c_WCNT_W'(MEM_TIMEOUT);

    logic [2:0]          r_state;
    logic [2:0]          r_cls;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0]    r_retired;
    logic                r_mem_err;

    logic [10:0]         w_op11;
    logic [2:0]          w_cls;
    logic [2:0]          w_next;
    logic [c_WCNT_W-1:0] w_wcnt_inc;
    logic [c_WCNT_W-1:0] w_wcnt_next;
    logic                w_expired;
    logic                w_retire;
    logic                w_timeout;

    assign w_op11     = op[OP_W-1 -: 11];
    assign w_wcnt_inc = r_wcnt + c_WCNT_W'(1);
    assign w_expired  = (w_wcnt_inc == c_WCNT_MAX);

    always_comb begin
        w_cls = c_K_ILL;
        casez (w_op11)
            11'b11111000010: w_cls = c_K_LDUR;
            11'b11111000000: w_cls = c_K_STUR;
            11'b10110100???: w_cls = c_K_CBZ;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: w_cls = c_K_RTYPE;
            default:         w_cls = c_K_ILL;
        endcase
    end

    // The wait counter defaults to clear, so any entry into FETCH/MEM starts at zero.
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = '0;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                if (imem_ready) begin
                    w_next = c_S_DECODE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = c_S_FETCH;
                end else begin
                    w_wcnt_next = w_wcnt_inc;
                end
            end
            c_S_DECODE: begin
                if (w_cls == c_K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = c_S_TRAP;
`else
                    w_next   = c_S_FETCH;
                    w_retire = 1'b1;
`endif
                end else begin
                    w_next = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                case (r_cls)
                    c_K_LDUR, c_K_STUR: w_next = c_S_MEM;
                    c_K_RTYPE:          w_next = c_S_WB;
                    c_K_CBZ: begin
                        w_next   = c_S_FETCH;
                        w_retire = 1'b1;
                    end
                    default:            w_next = c_S_FETCH;
                endcase
            end
            c_S_MEM: begin
                if (dmem_ready) begin
                    if (r_cls == c_K_LDUR) begin
                        w_next = c_S_WB;
                    end else begin
                        w_next   = c_S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = c_S_FETCH;
                end else begin
                    w_wcnt_next = w_wcnt_inc;
                end
            end
            c_S_WB: begin
                w_next   = c_S_FETCH;
                w_retire = 1'b1;
            end
            c_S_TRAP: w_next = c_S_TRAP;
            default:  w_next = c_S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is asserted, even though state reads FETCH.
    always_comb begin
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        reg2loc  = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        illegal  = 1'b0;
        if (reset) begin
            case (r_state)
                c_S_FETCH: begin
                    memread = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                c_S_DECODE: begin
                    reg2loc = (w_cls == c_K_STUR) || (w_cls == c_K_CBZ);
                    illegal = (w_cls == c_K_ILL);
                end
                c_S_EXEC: begin
                    alusrc = (r_cls == c_K_LDUR) || (r_cls == c_K_STUR);
                    if (r_cls == c_K_CBZ) begin
                        aluop  = 2'b01;
                        branch = 1'b1;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                    end else if (r_cls == c_K_RTYPE) begin
                        aluop = 2'b10;
                    end
                end
                c_S_MEM: begin
                    memread  = (r_cls == c_K_LDUR);
                    memwrite = (r_cls == c_K_STUR);
                end
                c_S_WB: begin
                    regwrite = 1'b1;
                    memtoreg = (r_cls == c_K_LDUR);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_S_FETCH;
            r_cls     <= c_K_NOP;
            r_wcnt    <= '0;
            r_retired <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (r_state == c_S_DECODE) begin
                r_cls <= w_cls;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign state   = r_state;
    assign retired = r_retired;
    assign mem_err = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed scoreboard bench for multicycle_ctrl; per-cycle expected
//            state/control vectors are queued, then popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam logic [12:0] K_ILL  = 13'h1000;
    localparam logic [12:0] K_IRW  = 13'h0800;
    localparam logic [12:0] K_PCW  = 13'h0400;
    localparam logic [12:0] K_PCS  = 13'h0200;
    localparam logic [12:0] K_R2L  = 13'h0100;
    localparam logic [12:0] K_ASRC = 13'h0080;
    localparam logic [12:0] K_M2R  = 13'h0040;
    localparam logic [12:0] K_RW   = 13'h0020;
    localparam logic [12:0] K_MR   = 13'h0010;
    localparam logic [12:0] K_MW   = 13'h0008;
    localparam logic [12:0] K_BR   = 13'h0004;
    localparam logic [12:0] K_A10  = 13'h0002;
    localparam logic [12:0] K_A01  = 13'h0001;
    localparam logic [12:0] K_FET  = K_MR | K_IRW | K_PCW;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_BAD  = 11'b11111110000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] op;
    logic        imem_ready, dmem_ready, zero;
    logic        ir_write, pc_write, pc_src, reg2loc, alusrc, memtoreg;
    logic        regwrite, memread, memwrite, branch, mem_err, illegal;
    logic [1:0]  aluop;
    logic [2:0]  state;
    logic [31:0] retired;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_ret = 0;

    typedef struct {
        logic [2:0]  st;
        logic [12:0] ctl;
        logic        im;
        logic        dm;
    } cyc_t;
    cyc_t sb[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.OP_W(11), .CNT_W(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .zero(zero), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
        .alusrc(alusrc), .memtoreg(memtoreg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch(branch),
        .aluop(aluop), .state(state), .retired(retired),
        .mem_err(mem_err), .illegal(illegal)
    );

    function automatic logic [12:0] ctl_now();
        return {illegal, ir_write, pc_write, pc_src, reg2loc, alusrc,
                memtoreg, regwrite, memread, memwrite, branch, aluop};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] st, input logic [12:0] ctl, input logic im, input logic dm);
        cyc_t c;
        c.st = st; c.ctl = ctl; c.im = im; c.dm = dm;
        sb.push_back(c);
    endtask

    // Each queued entry drives its ready inputs, is checked, then the clock advances.
    task automatic drain(input string tag);
        cyc_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            imem_ready = c.im;
            dmem_ready = c.dm;
            #1;
            chk({tag, "/state"}, 64'(state), 64'(c.st));
            chk({tag, "/ctl"}, 64'(ctl_now()), 64'(c.ctl));
            step();
        end
    endtask

    task automatic rtype(input logic [10:0] opv, input string tag);
        op = opv;
        push(3'd0, K_FET, 1'b1, 1'b0);
        push(3'd1, 13'h0, 1'b1, 1'b0);
        push(3'd2, K_A10, 1'b1, 1'b0);
        push(3'd4, K_RW,  1'b1, 1'b0);
        drain(tag);
        exp_ret++;
        chk({tag, "/retired"}, 64'(retired), 64'(exp_ret));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; op = '0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst/state", 64'(state), 64'd0);
        chk("rst/retired", 64'(retired), 64'd0);
        chk("rst/mem_err", 64'(mem_err), 64'd0);
        chk("rst/ctl", 64'(ctl_now()), 64'd0);
        reset = 1'b1;
        #1;
        chk("fetch_idle/ctl", 64'(ctl_now()), 64'(K_MR));

        op = OP_LDUR;
        push(3'd0, K_FET,         1'b1, 1'b1);
        push(3'd1, 13'h0,         1'b1, 1'b1);
        push(3'd2, K_ASRC,        1'b1, 1'b1);
        push(3'd3, K_MR,          1'b1, 1'b1);
        push(3'd4, K_RW | K_M2R,  1'b1, 1'b1);
        drain("ldur");
        exp_ret++;
        chk("ldur/end_state", 64'(state), 64'd0);
        chk("ldur/retired", 64'(retired), 64'(exp_ret));

        rtype(OP_ADD, "add");
        rtype(OP_SUB, "sub");
        rtype(OP_AND, "and");
        rtype(OP_ORR, "orr");

        op = OP_CBZ; zero = 1'b1;
        push(3'd0, K_FET, 1'b1, 1'b0);
        push(3'd1, K_R2L, 1'b1, 1'b0);
        push(3'd2, K_BR | K_A01 | K_PCW | K_PCS, 1'b1, 1'b0);
        drain("cbz_taken");
        zero = 1'b0;
        push(3'd0, K_FET, 1'b1, 1'b0);
        push(3'd1, K_R2L, 1'b1, 1'b0);
        push(3'd2, K_BR | K_A01, 1'b1, 1'b0);
        drain("cbz_not_taken");
        exp_ret += 2;
        chk("cbz/retired", 64'(retired), 64'(exp_ret));

        op = OP_STUR;
        push(3'd0, K_FET,  1'b1, 1'b0);
        push(3'd1, K_R2L,  1'b1, 1'b0);
        push(3'd2, K_ASRC, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push(3'd3, K_MW, 1'b1, (i == 3));
        drain("stur_stall");
        exp_ret++;
        chk("stur/end_state", 64'(state), 64'd0);
        chk("stur/retired", 64'(retired), 64'(exp_ret));

        // Ready arriving on the last allowed wait cycle must still be accepted.
        op = OP_ADD;
        for (int i = 0; i < 14; i++) push(3'd0, K_MR, 1'b0, 1'b0);
        push(3'd0, K_FET, 1'b1, 1'b0);
        push(3'd1, 13'h0, 1'b1, 1'b0);
        push(3'd2, K_A10, 1'b1, 1'b0);
        push(3'd4, K_RW,  1'b1, 1'b0);
        drain("late_ready");
        exp_ret++;
        chk("late_ready/mem_err", 64'(mem_err), 64'd0);
        chk("late_ready/retired", 64'(retired), 64'(exp_ret));

        for (int i = 0; i < 14; i++) push(3'd0, K_MR, 1'b0, 1'b0);
        drain("imem_wait");
        chk("imem_wait14/mem_err", 64'(mem_err), 64'd0);
        push(3'd0, K_MR, 1'b0, 1'b0);
        drain("imem_wait15");
        chk("imem_tmo/mem_err", 64'(mem_err), 64'd1);
        chk("imem_tmo/state", 64'(state), 64'd0);
        chk("imem_tmo/retired", 64'(retired), 64'(exp_ret));

        op = OP_LDUR;
        push(3'd0, K_FET,  1'b1, 1'b0);
        push(3'd1, 13'h0,  1'b1, 1'b0);
        push(3'd2, K_ASRC, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) push(3'd3, K_MR, 1'b1, 1'b0);
        push(3'd0, K_FET,  1'b1, 1'b0);
        drain("dmem_tmo");
        chk("dmem_tmo/retired", 64'(retired), 64'(exp_ret));
        chk("dmem_tmo/mem_err", 64'(mem_err), 64'd1);

        // The FETCH above already advanced into DECODE; finish it as an ADD.
        op = OP_ADD;
        push(3'd1, 13'h0, 1'b1, 1'b0);
        push(3'd2, K_A10, 1'b1, 1'b0);
        push(3'd4, K_RW,  1'b1, 1'b0);
        drain("after_tmo");
        exp_ret++;
        chk("after_tmo/retired", 64'(retired), 64'(exp_ret));
        chk("sticky/mem_err", 64'(mem_err), 64'd1);

        push(3'd0, K_FET, 1'b1, 1'b0);
        push(3'd1, 13'h0, 1'b1, 1'b0);
        drain("pre_abort");
        #1;
        chk("abort/in_exec", 64'(state), 64'd2);
        #1 reset = 1'b0;
        #1;
        chk("abort/state", 64'(state), 64'd0);
        chk("abort/mem_err", 64'(mem_err), 64'd0);
        chk("abort/retired", 64'(retired), 64'd0);
        chk("abort/ctl", 64'(ctl_now()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 0;
        rtype(OP_ADD, "post_reset");

        op = OP_BAD;
        push(3'd0, K_FET, 1'b1, 1'b0);
        push(3'd1, K_ILL, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) push(3'd5, 13'h0, 1'b1, 1'b1);
        drain("illegal_trap");
        chk("trap/state", 64'(state), 64'd5);
        chk("trap/retired", 64'(retired), 64'(exp_ret));
`else
        drain("illegal_nop");
        exp_ret++;
        chk("illegal_nop/state", 64'(state), 64'd0);
        chk("illegal_nop/retired", 64'(retired), 64'(exp_ret));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
